frame_sequencer: RTL and testbench

//  Output-side framing controller between packer and UART TX. Sequences each frame:
//  two sync bytes, frame-number byte, then exactly payload_bytes_p packed pixel bytes.

---
 rtl/frame_sequencer.sv | 99 +++++++++
 tb/tb_frame_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: wraps packer bytes into frames of sync0, sync1, frame number, payload.
// Optional FRAME_CHECKSUM_EN appends an XOR-of-payload trailer byte.
module frame_sequencer #(
  parameter int width_p = 8,
  parameter int payload_bytes_p = 76800,
  parameter logic [width_p-1:0] sync0_p = 8'hA5,
  parameter logic [width_p-1:0] sync1_p = 8'h5A
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] data_o,
  output logic               frame_active_o,
  output logic [7:0]         frame_count_o
);
  localparam int cnt_w_c = payload_bytes_p > 1 ? $clog2(payload_bytes_p) : 1;
  localparam logic [cnt_w_c-1:0] last_c = cnt_w_c'(payload_bytes_p - 1);
`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HNUM, PAY, CSUM} state_t;
  logic [width_p-1:0] r_csum;
`else
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HNUM, PAY} state_t;
`endif
  state_t r_state, w_next;
  logic [cnt_w_c-1:0] r_cnt;
  logic [7:0] r_fcnt;
  logic w_pay_hs, w_last, w_eof;
  assign w_pay_hs = (r_state == PAY) && valid_i && ready_i;
  assign w_last = w_pay_hs && (r_cnt == last_c);
  assign frame_active_o = r_state != IDLE;
  assign frame_count_o = r_fcnt;
  always_comb begin
    w_next = r_state;
    valid_o = 1'b0;
    ready_o = 1'b0;
    data_o = '0;
    w_eof = 1'b0;
    case (r_state)
      IDLE: w_next = enable_i ? HDR0 : IDLE;
      HDR0: begin
        valid_o = 1'b1;
        data_o = sync0_p;
        w_next = ready_i ? HDR1 : HDR0;
      end
      HDR1: begin
        valid_o = 1'b1;
        data_o = sync1_p;
        w_next = ready_i ? HNUM : HDR1;
      end
      HNUM: begin
        valid_o = 1'b1;
        data_o = width_p'(r_fcnt);
        w_next = ready_i ? PAY : HNUM;
      end
      PAY: begin
        valid_o = valid_i;
        ready_o = ready_i;
        data_o = data_i;
`ifdef FRAME_CHECKSUM_EN
        w_next = w_last ? CSUM : PAY;
`else
        w_eof = w_last;
`endif
      end
`ifdef FRAME_CHECKSUM_EN
      CSUM: begin
        valid_o = 1'b1;
        data_o = r_csum;
        w_eof = ready_i;
      end
`endif
      default: w_next = IDLE;
    endcase
    if (w_eof) w_next = enable_i ? HDR0 : IDLE;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_fcnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_pay_hs) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_eof) r_fcnt <= r_fcnt + 1'b1;
    end
  end
`ifdef FRAME_CHECKSUM_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_csum <= '0;
    else if (r_state != HDR0 && w_next == HDR0) r_csum <= '0;
    else if (w_pay_hs) r_csum <= r_csum ^ data_i;
  end
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: vector table plus randomized frames checked against a byte-stream model.
module tb_frame_sequencer;
  localparam int P = 4;
`ifdef FRAME_CHECKSUM_EN
  localparam int FL = P + 4;
`else
  localparam int FL = P + 3;
`endif
  typedef logic [7:0] byte_t;
  typedef struct {
    logic en, v, r;
    byte_t din;
    logic ev, er, act;
    byte_t ed, efc;
  } vec_t;
  logic clk = 1'b0, reset_i = 1'b0, enable_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic ready_o, valid_o, frame_active_o;
  byte_t data_i = 8'h00, data_o, frame_count_o;
  int total = 0, bad = 0;
  byte_t in_q[$], out_q[$], exp_q[$];
  bit v_hold, prev_stall;
  byte_t prev_data;
  vec_t tbl[13];

  frame_sequencer #(.width_p(8), .payload_bytes_p(P), .sync0_p(8'hA5), .sync1_p(8'h5A)) dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
    .frame_active_o(frame_active_o), .frame_count_o(frame_count_o));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    in_q = {};
    out_q = {};
    v_hold = 0;
    prev_stall = 0;
  endtask

  task automatic reset_dut();
    reset_i = 1;
    enable_i = 0;
    valid_i = 0;
    ready_i = 0;
    data_i = 0;
    repeat (2) @(negedge clk);
    reset_i = 0;
    clear_model();
  endtask

  // one clock: drive at negedge, observe combinational outputs, log handshakes
  task automatic cycle(input bit en, input bit v, input bit r);
    enable_i = en;
    ready_i = r;
    valid_i = in_q.size() > 0 && (v || v_hold);
    data_i = in_q.size() > 0 ? in_q[0] : 8'h00;
    #1;
    if (prev_stall) begin
      chk("stall_valid", 32'(valid_o), 1);
      chk("stall_data", 32'(data_o), 32'(prev_data));
    end
    prev_stall = valid_o && !ready_i;
    prev_data = data_o;
    if (valid_o && ready_i) out_q.push_back(data_o);
    if (valid_i && ready_o) void'(in_q.pop_front());
    v_hold = valid_i && !ready_o;
    @(negedge clk);
  endtask

  // pat: 0 random payload, 1 first frame 01..04, 2 first frame 01,02,04,08
  task automatic run_frames(input int n, input int k, input int rp, input int vp, input int pat, input bit do_rst);
    byte_t src[$];
    byte_t x;
    int thr, c;
    bit done;
    if (do_rst) reset_dut();
    clear_model();
    exp_q = {};
    for (int i = 0; i < n * P; i++)
      src.push_back(i < P && pat == 1 ? byte_t'(i + 1) : i < P && pat == 2 ? byte_t'(1 << i) : byte_t'($urandom));
    in_q = src;
    for (int f = 0; f < n; f++) begin
      x = 8'h00;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(byte_t'(f));
      for (int j = 0; j < P; j++) begin
        exp_q.push_back(src[f * P + j]);
        x ^= src[f * P + j];
      end
`ifdef FRAME_CHECKSUM_EN
      exp_q.push_back(x);
`endif
    end
    // enable drops k bytes into the last frame; it is only sampled at end-of-frame
    thr = (n - 1) * FL + 1 + k;
    done = 0;
    c = 0;
    while (!done && c < n * FL * 10 + 50) begin
      cycle(out_q.size() < thr, $urandom_range(99) < vp, $urandom_range(99) < rp);
      c++;
      chk("frame_count", 32'(frame_count_o), 32'((out_q.size() / FL) % 256));
      done = out_q.size() >= n * FL && !frame_active_o;
    end
    chk("finished", 32'(done), 1);
    if (rp == 100 && vp == 100) chk("cycles", c, 1 + n * FL);
    chk("out_len", out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) chk("out_byte", 32'(out_q[i]), 32'(exp_q[i]));
    chk("end_count", 32'(frame_count_o), 32'(n % 256));
    chk("end_idle", 32'(frame_active_o), 0);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 8'hA5, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 8'h00};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 8'h44, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 8'h66, 8'h00};
    reset_dut();
    valid_i = 1;
    data_i = 8'h99;
    #1;
    chk("reset_valid", 32'(valid_o), 0);
    chk("reset_ready", 32'(ready_o), 0);
    chk("reset_data", 32'(data_o), 0);
    chk("reset_active", 32'(frame_active_o), 0);
    chk("reset_count", 32'(frame_count_o), 0);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      enable_i = 0;
      valid_i = 1;
      ready_i = 1;
      data_i = 8'h3C;
      #1;
      chk("idle_valid", 32'(valid_o), 0);
      chk("idle_ready", 32'(ready_o), 0);
      chk("idle_active", 32'(frame_active_o), 0);
      @(negedge clk);
    end
    foreach (tbl[i]) begin
      enable_i = tbl[i].en;
      valid_i = tbl[i].v;
      ready_i = tbl[i].r;
      data_i = tbl[i].din;
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(tbl[i].er));
      chk($sformatf("vec%0d_active", i), 32'(frame_active_o), 32'(tbl[i].act));
      chk($sformatf("vec%0d_data", i), 32'(data_o), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_count", i), 32'(frame_count_o), 32'(tbl[i].efc));
      @(negedge clk);
    end
`ifdef FRAME_CHECKSUM_EN
    enable_i = 0;
    valid_i = 1;
    ready_i = 0;
    #1;
    chk("csum_valid", 32'(valid_o), 1);
    chk("csum_ready", 32'(ready_o), 0);
    chk("csum_data", 32'(data_o), 32'(8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66));
    @(negedge clk);
    ready_i = 1;
    #1;
    chk("csum_data_held", 32'(data_o), 32'(8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66));
    @(negedge clk);
`endif
    enable_i = 0;
    #1;
    chk("post_frame_idle", 32'(frame_active_o), 0);
    chk("post_frame_valid", 32'(valid_o), 0);
    chk("post_frame_count", 32'(frame_count_o), 1);
    @(negedge clk);

    run_frames(2, 0, 100, 100, 1, 1);
    run_frames(1, 4, 100, 100, 1, 1);
    for (int i = 0; i < 4; i++) run_frames(3, $urandom_range(FL - 2), 50, 70, 0, 1);
    run_frames(257, 0, 100, 100, 0, 1);
    chk("hnum_255", 32'(out_q[255 * FL + 2]), 32'h0FF);
`ifdef FRAME_CHECKSUM_EN
    run_frames(1, 0, 100, 100, 2, 1);
    chk("csum_trailer", 32'(out_q[P + 3]), 32'h0F);
`endif

    reset_dut();
    in_q = {8'h77, 8'h78, 8'h79, 8'h7A};
    for (int c = 0; c < 50 && out_q.size() < 5; c++) cycle(1, 1, 1);
    chk("pre_reset_bytes", out_q.size(), 5);
    enable_i = 1;
    valid_i = 1;
    ready_i = 1;
    data_i = 8'h79;
    #1;
    chk("pre_reset_pass", 32'(data_o), 32'h79);
    #2 reset_i = 1;
    #1;
    chk("midrst_valid", 32'(valid_o), 0);
    chk("midrst_ready", 32'(ready_o), 0);
    chk("midrst_data", 32'(data_o), 0);
    chk("midrst_active", 32'(frame_active_o), 0);
    chk("midrst_count", 32'(frame_count_o), 0);
    @(negedge clk);
    reset_i = 0;
    run_frames(1, 0, 100, 100, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
